// File: rtl/io_handshake_ctrl.sv
// io_handshake_ctrl
// Character I/O handshake controller for a small accumulator CPU.
// An input FSM tracks whether the input register holds an unread character
// (FGI). An output FSM tracks whether the output register is free (FGO).
// A bounded wait counter limits how long a character can wait for the output
// device, and a sticky error flag records any output protocol fault.
// Interrupt enable and request logic sits on top of both flags.
//
// Input FSM
//   state   | meaning
//   I_EMPTY | input register free, device may deliver a character
//   I_FULL  | character waiting for the CPU (FGI=1)
//
// Output FSM
//   state   | meaning
//   O_IDLE  | output register free, CPU may issue OUT (FGO=1)
//   O_SEND  | character presented to the device, waiting for ready

module io_handshake_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       dev_in_valid,
    input  logic [7:0] dev_in_data,
    output logic       dev_in_ready,
    output logic       inpr_load,
    output logic [7:0] inpr_data,

    input  logic       cpu_inp,
    input  logic       cpu_out,
    output logic       outr_load,
    output logic       dev_out_valid,
    input  logic       dev_out_ready,

    input  logic       cpu_ion,
    input  logic       cpu_iof,
    input  logic       cpu_intack,

    output logic       fgi,
    output logic       fgo,
    output logic       ien,
    output logic       ski,
    output logic       sko,
    output logic       irq,

    output logic       out_err,
    input  logic       err_clr
);

    localparam logic [0:0] I_EMPTY = 1'b0;
    localparam logic [0:0] I_FULL  = 1'b1;

    localparam logic [0:0] O_IDLE  = 1'b0;
    localparam logic [0:0] O_SEND  = 1'b1;

    // Last counter value before the wait is abandoned. A send that sees
    // this value without ready has used up TIMEOUT cycles in O_SEND.
    localparam logic [7:0] WAIT_LAST = TIMEOUT - 8'd1;

    logic [0:0] in_state_q;
    logic [0:0] in_state_d;
    logic [0:0] out_state_q;
    logic [0:0] out_state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic       ien_q;
    logic       ien_d;
    logic       out_err_q;
    logic       out_err_d;

    logic       in_empty;
    logic       out_idle;
    logic       in_take;
    logic       out_start;
    logic       out_timeout;
    logic       out_bad_cmd;

    // Decode current states and the strobes that move the FSMs.
    // Strobes are also gated by reset so nothing is loaded while it is held.
    always_comb begin
        in_empty    = (in_state_q == I_EMPTY);
        out_idle    = (out_state_q == O_IDLE);
        in_take     = reset & dev_in_valid & in_empty;
        out_start   = reset & cpu_out & out_idle;
        out_timeout = (out_state_q == O_SEND) & ~dev_out_ready
                      & (wait_cnt_q == WAIT_LAST);
        out_bad_cmd = cpu_out & (out_state_q == O_SEND);
    end

    // Input FSM: a device character fills the register, INP empties it.
    // In I_FULL the device is ignored, even in the cycle INP frees it.
    always_comb begin
        in_state_d = in_state_q;
        case (in_state_q)
            I_EMPTY: begin
                if (dev_in_valid) begin
                    in_state_d = I_FULL;
                end
            end
            I_FULL: begin
                if (cpu_inp) begin
                    in_state_d = I_EMPTY;
                end
            end
            default: in_state_d = I_EMPTY;
        endcase
    end

    // Output FSM: OUT starts a send, device ready or timeout ends it.
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            O_IDLE: begin
                if (cpu_out) begin
                    out_state_d = O_SEND;
                end
            end
            O_SEND: begin
                if (dev_out_ready || out_timeout) begin
                    out_state_d = O_IDLE;
                end
            end
            default: out_state_d = O_IDLE;
        endcase
    end

    // Wait counter: cleared on send start, counts while waiting for ready.
    // The terminal compare ends the send before the counter could wrap.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (out_idle) begin
            if (cpu_out) begin
                wait_cnt_d = 8'd0;
            end
        end else if (!dev_out_ready && !out_timeout) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Sticky output error: timeout or OUT while busy; set beats clear.
    always_comb begin
        out_err_d = out_err_q;
        if (out_timeout || out_bad_cmd) begin
            out_err_d = 1'b1;
        end else if (err_clr) begin
            out_err_d = 1'b0;
        end
    end

    // Interrupt enable: acknowledge over disable over enable.
    always_comb begin
        ien_d = ien_q;
        if (cpu_intack) begin
            ien_d = 1'b0;
        end else if (cpu_iof) begin
            ien_d = 1'b0;
        end else if (cpu_ion) begin
            ien_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q  <= I_EMPTY;
            out_state_q <= O_IDLE;
            wait_cnt_q  <= 8'd0;
            ien_q       <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wait_cnt_q  <= wait_cnt_d;
            ien_q       <= ien_d;
            out_err_q   <= out_err_d;
        end
    end

    // Outputs, all derived from registered state or the gated strobes.
    always_comb begin
        fgi           = (in_state_q == I_FULL);
        fgo           = out_idle;
        dev_in_ready  = in_empty;
        dev_out_valid = (out_state_q == O_SEND);
        inpr_load     = in_take;
        inpr_data     = dev_in_data;
        outr_load     = out_start;
        ien           = ien_q;
        ski           = fgi;
        sko           = fgo;
        irq           = ien_q & (fgi | fgo);
        out_err       = out_err_q;
    end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
module tb_io_handshake_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dev_in_valid;
    logic [7:0] dev_in_data;
    logic       dev_in_ready;
    logic       inpr_load;
    logic [7:0] inpr_data;
    logic       cpu_inp;
    logic       cpu_out;
    logic       outr_load;
    logic       dev_out_valid;
    logic       dev_out_ready;
    logic       cpu_ion;
    logic       cpu_iof;
    logic       cpu_intack;
    logic       fgi;
    logic       fgo;
    logic       ien;
    logic       ski;
    logic       sko;
    logic       irq;
    logic       out_err;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_handshake_ctrl #(.TIMEOUT(8'd4)) dut (
        .clk           (clk),
        .reset         (reset),
        .dev_in_valid  (dev_in_valid),
        .dev_in_data   (dev_in_data),
        .dev_in_ready  (dev_in_ready),
        .inpr_load     (inpr_load),
        .inpr_data     (inpr_data),
        .cpu_inp       (cpu_inp),
        .cpu_out       (cpu_out),
        .outr_load     (outr_load),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .cpu_ion       (cpu_ion),
        .cpu_iof       (cpu_iof),
        .cpu_intack    (cpu_intack),
        .fgi           (fgi),
        .fgo           (fgo),
        .ien           (ien),
        .ski           (ski),
        .sko           (sko),
        .irq           (irq),
        .out_err       (out_err),
        .err_clr       (err_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then move 1ns past it for driving/checking
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        dev_in_valid = 1'b0; dev_in_data = 8'h00;
        cpu_inp = 1'b0; cpu_out = 1'b0; dev_out_ready = 1'b0;
        cpu_ion = 1'b0; cpu_iof = 1'b0; cpu_intack = 1'b0; err_clr = 1'b0;
        #12;
        chk("rst_dev_in_ready", dev_in_ready, 1);
        chk("rst_fgi", fgi, 0);
        chk("rst_ski", ski, 0);
        chk("rst_fgo", fgo, 1);
        chk("rst_sko", sko, 1);
        chk("rst_dev_out_valid", dev_out_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ien", ien, 0);
        chk("rst_out_err", out_err, 0);

        // input character A5 after reset release
        tick();
        reset = 1'b1;
        dev_in_valid = 1'b1; dev_in_data = 8'hA5;
        #1;
        chk("in_load_pulse", inpr_load, 1);
        chk("in_load_data", inpr_data, 8'hA5);
        tick();
        chk("in_fgi_set", fgi, 1);
        chk("in_ski_set", ski, 1);
        chk("in_ready_low", dev_in_ready, 0);
        chk("in_full_ignores", inpr_load, 0);

        // INP while device still presents the next character
        dev_in_data = 8'h3C;
        cpu_inp = 1'b1;
        #1;
        chk("inp_no_load_same", inpr_load, 0);
        tick();
        cpu_inp = 1'b0;
        #1;
        chk("inp_fgi_clear", fgi, 0);
        chk("inp_load_next", inpr_load, 1);
        chk("inp_load_data", inpr_data, 8'h3C);
        tick();
        dev_in_valid = 1'b0;
        chk("inp_refill", fgi, 1);

        // interrupts: enable, then acknowledge beats enable
        cpu_ion = 1'b1;
        tick();
        cpu_ion = 1'b0;
        chk("ion_ien", ien, 1);
        chk("ion_irq", irq, 1);
        cpu_intack = 1'b1; cpu_ion = 1'b1;
        tick();
        cpu_intack = 1'b0; cpu_ion = 1'b0;
        chk("ack_ien", ien, 0);
        chk("ack_irq", irq, 0);

        // INP in I_EMPTY has no effect
        cpu_inp = 1'b1;
        tick();
        cpu_inp = 1'b0;
        chk("inp_empties", fgi, 0);
        cpu_inp = 1'b1;
        tick();
        cpu_inp = 1'b0;
        chk("inp_empty_noop", fgi, 0);
        chk("inp_empty_ready", dev_in_ready, 1);

        // normal output transfer, device ready in third send cycle
        cpu_out = 1'b1;
        #1;
        chk("out_load_pulse", outr_load, 1);
        tick();
        cpu_out = 1'b0;
        #1;
        chk("out_load_once", outr_load, 0);
        chk("out_fgo_low", fgo, 0);
        chk("out_sko_low", sko, 0);
        chk("out_valid_high", dev_out_valid, 1);
        tick();
        tick();
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        chk("out_done_fgo", fgo, 1);
        chk("out_done_valid", dev_out_valid, 0);
        chk("out_done_err", out_err, 0);

        // timeout with TIMEOUT=4: four cycles in O_SEND
        cpu_out = 1'b1;
        tick();
        cpu_out = 1'b0;
        tick();
        tick();
        tick();
        chk("to_still_send", dev_out_valid, 1);
        chk("to_no_err_yet", out_err, 0);
        tick();
        chk("to_err_set", out_err, 1);
        chk("to_fgo_back", fgo, 1);
        chk("to_valid_drop", dev_out_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("errclr_clears", out_err, 0);

        // a fresh send after timeout restarts the counter from zero
        cpu_out = 1'b1;
        tick();
        cpu_out = 1'b0;
        tick();
        tick();
        tick();
        chk("to2_restart", dev_out_valid, 1);
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        chk("to2_ok_err", out_err, 0);

        // OUT while busy: no load strobe, error set wins over clear
        cpu_out = 1'b1;
        tick();
        err_clr = 1'b1;
        #1;
        chk("busy_out_noload", outr_load, 0);
        tick();
        cpu_out = 1'b0; err_clr = 1'b0;
        chk("busy_out_err", out_err, 1);
        chk("busy_still_send", dev_out_valid, 1);
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;

        // reset during a send acts without a clock edge
        cpu_out = 1'b1;
        tick();
        cpu_out = 1'b0;
        chk("pre_rst_valid", dev_out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", dev_out_valid, 0);
        chk("arst_fgo", fgo, 1);
        chk("arst_err", out_err, 0);
        cpu_out = 1'b1;
        #1;
        chk("arst_no_load", outr_load, 0);
        cpu_out = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_fgo", fgo, 1);
        chk("post_rst_valid", dev_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_handshake_ctrl.md
IO_HANDSHAKE_CTRL -- requirements
Module: io_handshake_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 8'd200, maximum cycles dev_out_valid waits for dev_out_ready (legal 1..255).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces the reset state immediately, independent of clk.
REQ-004 dev_in_valid  in  1  input device presents a character.
REQ-005 dev_in_data  in  8  input device character.
REQ-006 dev_in_ready  out  1  controller can accept a character.
REQ-007 inpr_load  out  1  load strobe to the 8-bit input register.
REQ-008 inpr_data  out  8  data to the input register, equal to dev_in_data.
REQ-009 cpu_inp / cpu_out  in  1 each  one-cycle INP / OUT instruction strobes.
REQ-010 outr_load  out  1  load strobe to the 8-bit output register (AC[7:0] captured externally).
REQ-011 dev_out_valid  out  1  output register holds a character for the device.
REQ-012 dev_out_ready  in  1  output device accepts the character.
REQ-013 cpu_ion / cpu_iof / cpu_intack  in  1 each  interrupt enable set / clear / interrupt acknowledge.
REQ-014 fgi, fgo, ien  out  1 each  input flag, output flag, interrupt enable.
REQ-015 ski, sko, irq  out  1 each  skip-on-FGI, skip-on-FGO, interrupt request.
REQ-016 out_err  out  1  sticky output protocol/timeout error; err_clr  in  1  clears it.

Function
REQ-017 Input FSM states I_EMPTY, I_FULL; fgi SHALL be 1 exactly in I_FULL; dev_in_ready SHALL be 1 exactly in I_EMPTY.
REQ-018 inpr_load SHALL equal dev_in_valid AND I_EMPTY (combinational), so the register captures on the same edge that moves I_EMPTY -> I_FULL.
REQ-019 In I_FULL, cpu_inp SHALL move to I_EMPTY (fgi 0 next cycle); cpu_inp in I_EMPTY SHALL have no effect.
REQ-020 In I_FULL, dev_in_valid SHALL be ignored (no load); with simultaneous cpu_inp, the new character is not taken that cycle.
REQ-021 Output FSM states O_IDLE, O_SEND; fgo SHALL be 1 exactly in O_IDLE; dev_out_valid SHALL be 1 exactly in O_SEND.
REQ-022 outr_load SHALL equal cpu_out AND O_IDLE (combinational); that edge moves O_IDLE -> O_SEND and clears the 8-bit wait counter.
REQ-023 In O_SEND, dev_out_ready SHALL return to O_IDLE on that edge; otherwise the counter increments.
REQ-024 Counter reaching TIMEOUT-1 without dev_out_ready SHALL set out_err and return to O_IDLE (character dropped); counter SHALL never wrap.
REQ-025 cpu_out during O_SEND SHALL NOT pulse outr_load and SHALL set out_err.
REQ-026 err_clr SHALL clear out_err; a set condition in the same cycle SHALL win.
REQ-027 ien: cpu_ion sets, cpu_iof clears, cpu_intack clears; priority intack > iof > ion.
REQ-028 irq SHALL equal ien AND (fgi OR fgo); ski = fgi; sko = fgo; all combinational from registers.
REQ-029 Input and output FSMs SHALL operate independently and concurrently.

Reset
REQ-030 While reset low: I_EMPTY, O_IDLE, fgi=0, fgo=1, ien=0, out_err=0, counter=0; hence dev_in_ready=1, dev_out_valid=0, irq=0, ski=0, sko=1.
REQ-031 Reset asserted mid-transfer SHALL abandon it without load strobes or error; the first edge after release uses reset state.

Verification
REQ-032 Reset release, dev_in_valid=1, dev_in_data=8'hA5 -> inpr_load=1 one cycle, inpr_data=8'hA5, next cycle fgi=1, ski=1, dev_in_ready=0.
REQ-033 I_FULL, cpu_inp with dev_in_valid=1 same cycle -> fgi=0 next cycle, no inpr_load that cycle, load on following edge.
REQ-034 cpu_out in O_IDLE -> outr_load pulse, fgo=0, dev_out_valid=1; dev_out_ready after 3 cycles -> fgo=1, out_err=0.
REQ-035 TIMEOUT=4, cpu_out, dev_out_ready held 0 -> out_err=1 and fgo=1 after 4 cycles in O_SEND; err_clr -> out_err=0.
REQ-036 cpu_ion then fgi=1 -> irq=1; cpu_intack with cpu_ion same cycle -> ien=0, irq=0.
REQ-037 reset asserted during O_SEND -> immediately dev_out_valid=0, fgo=1, out_err=0 without a clock edge.
